// File: rtl/dot_scan_pkg.sv
// dot_scan_pkg
//   Shared constants and helpers for the dot-matrix column-scan driver.
//   - DEF_NCOL / DEF_NROW / DEF_DWELL / DEF_BLANK : default geometry and timing
//   - BRIGHT_W  : width of the brightness control
//   - cnt_width : bit width needed by a counter running 0..dwell-1
package dot_scan_pkg;

  localparam int DEF_NCOL  = 10;
  localparam int DEF_NROW  = 7;
  localparam int DEF_DWELL = 1000;
  localparam int DEF_BLANK = 16;

  localparam int BRIGHT_W  = 3;

  // A counter that must hold dwell-1 needs clog2(dwell) bits; never
  // return zero so a degenerate dwell still gives a legal vector.
  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/dot_scan_timer.sv
// dot_scan_timer
//   Per-column dwell counter and column counter for the scan driver.
//   Both counters only move while en is high.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   en         in   scan enable; counters hold when low
//   tick       out  position inside the current column, 0..DWELL-1
//   col        out  current column, 0..NCOL-1
//   col_wrap   out  high in the cycle whose edge ends the current column
//   frame_wrap out  high in the cycle whose edge ends the whole frame
module dot_scan_timer
  import dot_scan_pkg::*;
#(
  parameter int NCOL  = DEF_NCOL,
  parameter int DWELL = DEF_DWELL
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  output logic [cnt_width(DWELL)-1:0] tick,
  output logic [$clog2(NCOL)-1:0]     col,
  output logic                        col_wrap,
  output logic                        frame_wrap
);

  localparam int TW = cnt_width(DWELL);
  localparam int CW = $clog2(NCOL);

  localparam logic [TW-1:0] TICK_LAST = TW'(DWELL - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(NCOL - 1);

  // Wrap flags are qualified by en so a stalled scan never commits anything.
  assign col_wrap   = en && (tick == TICK_LAST);
  assign frame_wrap = col_wrap && (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= '0;
      col  <= '0;
    end else if (en) begin
      if (col_wrap) begin
        tick <= '0;
        col  <= (col == COL_LAST) ? '0 : col + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dot_scan_ctrl.sv
// dot_scan_ctrl
//   Column-scan driver for a multiplexed LED dot matrix with a
//   double-buffered frame store. Writes always go to the back bank; a swap
//   request is held pending and committed only on the frame wrap, so a
//   frame is never shown half old / half new.
//   Each column lasts DWELL clocks; the first BLANK of them drive nothing
//   to stop ghosting between columns.
//   Optional feature macro: DOT_SCAN_DIM_EN
//     defined   : dot_d is PWM-gated by brightness (on while tick[2:0] <= brightness)
//     undefined : brightness is ignored, dots full-on during the active period
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset (clears both banks)
//   en           in   scan enable; low freezes the scan and blanks outputs
//   wr_en        in   write strobe into the back bank
//   wr_addr      in   column to write; values >= NCOL are ignored
//   wr_data      in   dot pattern for that column
//   swap         in   request to exchange front and back banks
//   brightness   in   PWM level, 0 dimmest .. 7 full
//   swap_pending out  swap accepted but not yet committed
//   frame_start  out  one-cycle strobe for the tick=0, col=0 output cycle
//   dot_d        out  row drive for the active column
//   dot_scan     out  one-hot column select or all zero
// All outputs are registered from the pre-edge (tick, col) state.
module dot_scan_ctrl
  import dot_scan_pkg::*;
#(
  parameter int NCOL  = DEF_NCOL,
  parameter int NROW  = DEF_NROW,
  parameter int DWELL = DEF_DWELL,
  parameter int BLANK = DEF_BLANK
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [$clog2(NCOL)-1:0] wr_addr,
  input  logic [NROW-1:0]         wr_data,
  input  logic                    swap,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic                    swap_pending,
  output logic                    frame_start,
  output logic [NROW-1:0]         dot_d,
  output logic [NCOL-1:0]         dot_scan
);

  localparam int AW = $clog2(NCOL);
  localparam int TW = cnt_width(DWELL);

  localparam logic [AW:0]     NCOL_EXT = NCOL[AW:0];
  localparam logic [NCOL-1:0] COL_ONE  = {{(NCOL-1){1'b0}}, 1'b1};

  logic [TW-1:0]   tick;
  logic [AW-1:0]   col;
  logic            unused_col_wrap;
  logic            frame_wrap;

  // Two banks; front_bank selects the one on display, the other takes writes.
  logic [NROW-1:0] bank_mem [2][NCOL];
  logic            front_bank;
  logic            back_bank;

  logic            addr_ok;
  logic            active;
  logic            show_dots;
  logic [NROW-1:0] front_word;

  dot_scan_timer #(
    .NCOL  (NCOL),
    .DWELL (DWELL)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .tick       (tick),
    .col        (col),
    .col_wrap   (unused_col_wrap),
    .frame_wrap (frame_wrap)
  );

  assign back_bank  = ~front_bank;
  // Zero-extended so the range test stays meaningful when NCOL is not a
  // power of two.
  assign addr_ok    = ({1'b0, wr_addr} < NCOL_EXT);
  // Signed integer compare keeps BLANK = 0 well defined.
  assign active     = en && (int'(tick) >= BLANK);
  assign front_word = bank_mem[front_bank][col];

`ifdef DOT_SCAN_DIM_EN
  // PWM over the low three tick bits: level n lights n+1 of every 8 clocks.
  assign show_dots = (BRIGHT_W'(tick) <= brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign show_dots         = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NCOL; c++) begin
          bank_mem[b][c] <= '0;
        end
      end
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      dot_d        <= '0;
      dot_scan     <= '0;
      frame_start  <= 1'b0;
    end else begin
      // A write in the commit cycle lands in the bank that is about to
      // become front, because back_bank is taken from the pre-edge value.
      if (wr_en && addr_ok) begin
        bank_mem[back_bank][wr_addr] <= wr_data;
      end

      // Commit wins over a coincident request; that request is dropped.
      if (frame_wrap && swap_pending) begin
        front_bank   <= ~front_bank;
        swap_pending <= 1'b0;
      end else if (swap) begin
        swap_pending <= 1'b1;
      end

      dot_scan    <= active ? (COL_ONE << col) : '0;
      dot_d       <= (active && show_dots) ? front_word : '0;
      frame_start <= en && (tick == '0) && (col == '0);
    end
  end

endmodule

// File: tb/tb_dot_scan_ctrl.sv
// tb_dot_scan_ctrl
//   Bench for dot_scan_ctrl with NCOL=4, NROW=7, DWELL=8, BLANK=2.
//   Reference model keeps the frame position as one integer and the two
//   frame images as plain arrays that are exchanged on commit.
module tb_dot_scan_ctrl;

  localparam int NCOL  = 4;
  localparam int NROW  = 7;
  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NCOL * DWELL;
  localparam int AW    = $clog2(NCOL);
  localparam int EW    = NCOL + NROW + 2;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [NROW-1:0] wr_data;
  logic            swap;
  logic [2:0]      brightness;
  logic            swap_pending;
  logic            frame_start;
  logic [NROW-1:0] dot_d;
  logic [NCOL-1:0] dot_scan;

  always #5 clk = ~clk;

  dot_scan_ctrl #(
    .NCOL  (NCOL),
    .NROW  (NROW),
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap         (swap),
    .brightness   (brightness),
    .swap_pending (swap_pending),
    .frame_start  (frame_start),
    .dot_d        (dot_d),
    .dot_scan     (dot_scan)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NROW-1:0] m_front[NCOL];
  logic [NROW-1:0] m_back[NCOL];
  logic            m_pend = 1'b0;
  int              m_pos  = 0;

  function automatic logic [NROW-1:0] gate(input logic [NROW-1:0] d, input int tick);
`ifdef DOT_SCAN_DIM_EN
    return ((tick % 8) <= int'(brightness)) ? d : '0;
`else
    return (tick >= 0) ? d : '0;
`endif
  endfunction

  // One clock: predict from the pre-edge model, clock, sample, compare,
  // leaving the model in its post-edge state.
  task automatic cycle();
    int              col;
    int              tick;
    logic [NCOL-1:0] s;
    logic [NROW-1:0] d;
    logic [NROW-1:0] tmp;
    logic            fs;
    logic [EW-1:0]   e;
    logic [EW-1:0]   act;
    col = m_pos / DWELL;
    tick = m_pos % DWELL;
    if (reset) begin
      for (int i = 0; i < NCOL; i++) begin
        m_front[i] = '0;
        m_back[i]  = '0;
      end
      m_pend = 1'b0;
      m_pos  = 0;
      e = '0;
    end else begin
      s = '0;
      d = '0;
      if (en && tick >= BLANK) begin
        s = NCOL'(1 << col);
        d = gate(m_front[col], tick);
      end
      fs = en && (m_pos == 0);
      if (wr_en && int'(wr_addr) < NCOL) m_back[wr_addr] = wr_data;
      if (en && m_pos == FRAME - 1 && m_pend) begin
        for (int i = 0; i < NCOL; i++) begin
          tmp        = m_front[i];
          m_front[i] = m_back[i];
          m_back[i]  = tmp;
        end
        m_pend = 1'b0;
      end else if (swap) begin
        m_pend = 1'b1;
      end
      if (en) m_pos = (m_pos + 1) % FRAME;
      e = {s, d, fs, m_pend};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    act = {dot_scan, dot_d, frame_start, swap_pending};
    check("model", act, exp_q.pop_front());
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (m_pos != target && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    if (m_pos != target) begin
      checks++;
      errors++;
      $display("FAIL run_to: position %0d expected %0d", m_pos, target);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            rst;
    logic            en;
    logic            wr_en;
    logic [AW-1:0]   addr;
    logic [NROW-1:0] data;
    logic            swap;
    logic [NCOL-1:0] e_scan;
    logic [NROW-1:0] e_d;
    logic            e_fs;
    logic            e_pend;
  } vec_t;

  vec_t tbl[10];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    logic [NROW-1:0] pat_c[4];
    pat_c = '{7'h11, 7'h22, 7'h44, 7'h7F};

    reset = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    swap = 1'b0; brightness = 3'd7;

    //          rst   en    wr    addr  data   swap  scan  d      fs    pend
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 7'h00, 1'b0, 4'h0, 7'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 2'd0, 7'h7F, 1'b1, 4'h0, 7'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 2'd0, 7'h01, 1'b0, 4'h0, 7'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 2'd1, 7'h02, 1'b0, 4'h0, 7'h00, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 2'd2, 7'h04, 1'b0, 4'h0, 7'h00, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd3, 7'h08, 1'b0, 4'h0, 7'h00, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 4'h0, 7'h00, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 2'd0, 7'h00, 1'b0, 4'h0, 7'h00, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 2'd0, 7'h00, 1'b0, 4'h0, 7'h00, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 2'd0, 7'h00, 1'b0, 4'h1, 7'h00, 1'b0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst; en = tbl[i].en; wr_en = tbl[i].wr_en;
      wr_addr = tbl[i].addr; wr_data = tbl[i].data; swap = tbl[i].swap;
      cycle();
      check("tbl_scan", dot_scan, tbl[i].e_scan);
      check("tbl_d", dot_d, tbl[i].e_d);
      check("tbl_fs", frame_start, tbl[i].e_fs);
      check("tbl_pend", swap_pending, tbl[i].e_pend);
    end
    reset = 1'b0; wr_en = 1'b0; swap = 1'b0; en = 1'b1;

    // Load and swap: pending until the 32nd enabled clock, then new image.
    cnt = 0;
    while (swap_pending && cnt < 40) begin
      cycle();
      cnt++;
    end
    check("commit_latency", cnt, 29);
    for (int p = 0; p < FRAME; p++) begin
      int c;
      int t;
      c = p / DWELL;
      t = p % DWELL;
      cycle();
      check("frame_scan", dot_scan, (t < BLANK) ? 0 : (1 << c));
      check("frame_d", dot_d, (t < BLANK) ? 0 : (1 << c));
      check("frame_fs", frame_start, (p == 0) ? 1 : 0);
    end

    // Enable stall at col 1, tick 4 for 5 clocks.
    run_to(12);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_scan", dot_scan, 0);
      check("stall_d", dot_d, 0);
    end
    en = 1'b1;
    cycle();
    check("resume_scan", dot_scan, 4'b0010);
    check("resume_d", dot_d, 7'h02);
    cnt = 0;
    while (cnt < 40) begin
      cycle();
      cnt++;
      if (frame_start) break;
    end
    check("stall_frame_len", cnt, 20);

    // Second swap while pending, swap and write in the commit cycle.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = pat_c[i];
      cycle();
    end
    wr_en = 1'b0;
    swap = 1'b1; cycle(); swap = 1'b0;
    check("pend_set", swap_pending, 1);
    cycle(); cycle();
    swap = 1'b1; cycle(); swap = 1'b0;
    check("pend_second", swap_pending, 1);
    run_to(FRAME - 1);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 7'h55; swap = 1'b1;
    cycle();
    wr_en = 1'b0; swap = 1'b0;
    check("swap_at_commit", swap_pending, 0);
    run_to(10);
    cycle();
    check("commit_write_scan", dot_scan, 4'b0010);
    check("commit_write_d", dot_d, 7'h55);
    run_to(2);
    cycle();
    check("single_toggle_d", dot_d, 7'h11);
    check("single_toggle_pend", swap_pending, 0);

    // Mid-frame reset at col 2 with a swap pending.
    run_to(17);
    swap = 1'b1; cycle(); swap = 1'b0;
    cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    check("rst_scan", dot_scan, 0);
    check("rst_d", dot_d, 0);
    check("rst_fs", frame_start, 0);
    check("rst_pend", swap_pending, 0);
    for (int p = 0; p < FRAME; p++) begin
      cycle();
      check("post_reset_dark", dot_d, 0);
    end

`ifdef DOT_SCAN_DIM_EN
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 7'h7F; cycle(); wr_en = 1'b0;
    swap = 1'b1; cycle(); swap = 1'b0;
    run_to(FRAME - 1);
    cycle();
    brightness = 3'd3;
    for (int p = 0; p < DWELL; p++) begin
      cycle();
      check("dim3_d", dot_d, (p >= 2 && p <= 3) ? 7'h7F : 7'h00);
      check("dim3_scan", dot_scan, (p >= 2) ? 1 : 0);
    end
    run_to(0);
    brightness = 3'd7;
    for (int p = 0; p < DWELL; p++) begin
      cycle();
      check("dim7_d", dot_d, (p >= 2) ? 7'h7F : 7'h00);
    end
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset      = ($urandom_range(0, 149) == 0);
      en         = ($urandom_range(0, 7) != 0);
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_addr    = AW'($urandom_range(0, NCOL - 1));
      wr_data    = NROW'($urandom);
      swap       = ($urandom_range(0, 24) == 0);
      brightness = 3'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
